// File: rtl/mux32_arbiter_if.sv
// Bundles the request/data/grant and output-beat signals of the 4-way round-robin arbiter.
interface mux32_arbiter_if;
  logic [3:0]  req;
  logic [31:0] data0;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [31:0] data3;
  logic        out_ready;
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic [31:0] out_data;
  logic        out_valid;

  modport master (
    output req, data0, data1, data2, data3, out_ready,
    input  gnt, sel, out_data, out_valid
  );

  modport slave (
    input  req, data0, data1, data2, data3, out_ready,
    output gnt, sel, out_data, out_valid
  );
endinterface

// File: rtl/mux32_arbiter.sv
// Round-robin arbiter over four 32-bit requesters with bounded bursts and a
// single registered output slot that honours downstream backpressure.
//
// state | meaning
// IDLE  | no owner; pick next requester starting from ptr
// GRANT | owner holds the datapath for up to BURST beats
module mux32_arbiter #(
  parameter int BURST = 4
) (
  input logic         clk,
  input logic         reset,
  mux32_arbiter_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t      state;
  logic [1:0]  owner;
  logic [1:0]  ptr;
  logic [3:0]  cnt;
  logic [1:0]  sel;
  logic [31:0] out_data;
  logic        out_valid;

  logic        slot_free;
  logic        beat;
  logic [1:0]  pick;
  logic [31:0] word;

  assign slot_free = !out_valid || bus.out_ready;
  assign beat      = (state == GRANT) && bus.req[owner] && slot_free && !reset;

  // Scan downward so the requester closest to ptr is the last (winning) assignment.
  always_comb begin
    pick = ptr;
    for (int i = 3; i >= 0; i--) begin
      if (bus.req[ptr + 2'(i)]) pick = ptr + 2'(i);
    end
  end

  always_comb begin
    word = bus.data0;
    case (sel)
      2'd0: word = bus.data0;
      2'd1: word = bus.data1;
      2'd2: word = bus.data2;
      2'd3: word = bus.data3;
      default: word = bus.data0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= 2'd0;
      ptr       <= 2'd0;
      cnt       <= 4'd0;
      sel       <= 2'd0;
      out_data  <= 32'd0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req != 4'd0) begin
            owner <= pick;
            sel   <= pick;
            cnt   <= 4'd0;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (!bus.req[owner]) begin
            state <= IDLE;
            ptr   <= owner + 2'd1;
          end else if (slot_free) begin
            cnt <= cnt + 4'd1;
            if (cnt + 4'd1 == 4'(BURST)) begin
              state <= IDLE;
              ptr   <= owner + 2'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // The output slot is independent of arbitration so a pending beat outlives its grant.
      if (beat) begin
        out_data  <= word;
        out_valid <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.gnt       = beat ? (4'b0001 << owner) : 4'b0000;
  assign bus.sel       = sel;
  assign bus.out_data  = out_data;
  assign bus.out_valid = out_valid;

endmodule

// File: tb/tb_mux32_arbiter.sv
// Randomized scoreboard bench for mux32_arbiter against a behavioural round-robin model.
module tb_mux32_arbiter;
  localparam int BURST = 4;

  logic clk = 1'b0;
  logic reset;
  mux32_arbiter_if bus ();

  mux32_arbiter #(.BURST(BURST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] expq[$];

  // Behavioural model: who holds the bus, how many beats it has had, where the scan starts.
  bit          m_busy;
  int          m_owner;
  int          m_ptr;
  int          m_beats;
  int          m_sel;
  bit          m_valid;

  function automatic int rr_pick(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++)
      if (r[(start + k) % 4]) return (start + k) % 4;
    return start;
  endfunction

  function automatic logic [31:0] data_of(input int idx);
    case (idx)
      0: return bus.data0;
      1: return bus.data1;
      2: return bus.data2;
      default: return bus.data3;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic [3:0] r, input logic rdy, input logic rst);
    bit          slot;
    bit          exp_beat;
    logic [3:0]  exp_gnt;
    @(posedge clk);
    #1;
    reset         = rst;
    bus.req       = r;
    bus.out_ready = rdy;
    bus.data0     = $urandom;
    bus.data1     = $urandom;
    bus.data2     = $urandom;
    bus.data3     = $urandom;
    #1;
    check("sel", {30'd0, bus.sel}, m_sel);
    check("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});

    slot     = !m_valid || rdy;
    exp_beat = !rst && m_busy && r[m_owner] && slot;
    exp_gnt  = exp_beat ? 4'(1 << m_owner) : 4'd0;
    check("gnt", {28'd0, bus.gnt}, {28'd0, exp_gnt});
    if (exp_beat) expq.push_back(data_of(m_owner));

    if (rst) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_beats = 0; m_sel = 0; m_valid = 0;
      expq.delete();
    end else begin
      if (exp_beat) m_valid = 1;
      else if (rdy) m_valid = 0;
      if (!m_busy) begin
        if (r != 4'd0) begin
          m_owner = rr_pick(r, m_ptr);
          m_sel   = m_owner;
          m_beats = 0;
          m_busy  = 1;
        end
      end else if (!r[m_owner]) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % 4;
      end else if (slot) begin
        m_beats++;
        if (m_beats == BURST) begin
          m_busy = 0;
          m_ptr  = (m_owner + 1) % 4;
        end
      end
    end
  endtask

  // Output monitor: every presented beat must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.out_valid === 1'b1) begin
      if (expq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL out_data: got %h expected none (queue empty) at %0t", bus.out_data, $time);
      end else begin
        check("out_data", bus.out_data, expq[0]);
        if (bus.out_ready) void'(expq.pop_front());
      end
    end
  end

  initial begin
    logic [3:0] r;
    reset = 1'b1;
    bus.req = 4'd0;
    bus.out_ready = 1'b0;
    bus.data0 = '0; bus.data1 = '0; bus.data2 = '0; bus.data3 = '0;
    m_busy = 0; m_owner = 0; m_ptr = 0; m_beats = 0; m_sel = 0; m_valid = 0;
    repeat (2) @(posedge clk);

    // Single-requester latency, then held all-request rotation with wrap.
    cycle(4'b0010, 1'b1, 1'b0);
    repeat (3) cycle(4'b0010, 1'b1, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0);
    repeat (30) cycle(4'b1111, 1'b1, 1'b0);
    repeat (4) cycle(4'b1001, 1'b1, 1'b0);
    // Backpressure while requester 1 owns the bus.
    cycle(4'b0000, 1'b1, 1'b1);
    cycle(4'b0010, 1'b1, 1'b0);
    cycle(4'b0010, 1'b1, 1'b0);
    repeat (3) cycle(4'b0010, 1'b0, 1'b0);
    repeat (4) cycle(4'b0010, 1'b1, 1'b0);
    // Early release by requester 2, then reset in mid-grant.
    cycle(4'b0000, 1'b1, 1'b1);
    cycle(4'b0100, 1'b1, 1'b0);
    cycle(4'b0100, 1'b1, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0);
    repeat (3) cycle(4'b0101, 1'b1, 1'b0);
    cycle(4'b0100, 1'b1, 1'b1);
    repeat (3) cycle(4'b1000, 1'b1, 1'b0);

    r = 4'b0000;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 9) < 2) r[b] = ~r[b];
      cycle(r, ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) < 2));
    end
    cycle(4'b0000, 1'b1, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux32_arbiter.md
MUX32_ARBITER -- requirements
Module: mux32_arbiter

Interface
REQ-001 SHALL have parameter BURST, default 4, meaning maximum beats transferred per grant before rotation (legal range 1..15).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port req  input  4  per-requester request, bit i = requester i.
REQ-005 SHALL have ports data0, data1, data2, data3  input  32 each  requester data words.
REQ-006 SHALL have port out_ready  input  1  downstream accepts out_data this cycle.
REQ-007 SHALL have port gnt  output  4  one-hot beat-accept strobe to requesters.
REQ-008 SHALL have port sel  output  2  registered select for the shared 32-bit 4:1 datapath mux (00..11 = data0..data3).
REQ-009 SHALL have port out_data  output  32  registered selected word.
REQ-010 SHALL have port out_valid  output  1  out_data holds an unaccepted beat.

Function
REQ-011 SHALL implement FSM states IDLE and GRANT, plus registers owner[1:0], ptr[1:0], cnt[3:0].
REQ-012 IDLE: if req != 0, SHALL pick first set bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4), load owner and sel with it, clear cnt, go GRANT; else remain IDLE.
REQ-013 Arbitration SHALL take exactly one cycle: req sampled in IDLE at cycle N, GRANT active at N+1.
REQ-014 Output slot free SHALL be defined as (!out_valid || out_ready).
REQ-015 In GRANT, a beat SHALL occur when req[owner]=1 and slot free; gnt[owner]=1 combinationally in that cycle only, all other gnt bits 0.
REQ-016 gnt SHALL be 0 in IDLE and in any GRANT cycle without a beat.
REQ-017 On a beat, out_data SHALL load data selected by owner and out_valid SHALL be 1 next cycle (one-cycle latency gnt -> out_valid).
REQ-018 When out_valid=1, out_ready=1 and no beat, out_valid SHALL clear next cycle; out_data holds.
REQ-019 When out_valid=1 and out_ready=0, out_data and out_valid SHALL hold (backpressure); cnt and state unchanged.
REQ-020 On a beat, cnt SHALL increment; if cnt+1 == BURST, SHALL go IDLE and set ptr = owner+1 (mod 4, wraps 3 -> 0).
REQ-021 In GRANT with req[owner]=0, SHALL go IDLE with ptr = owner+1, no beat issued.
REQ-022 Requests from non-owners SHALL be ignored during GRANT; they are served only via IDLE re-arbitration.
REQ-023 sel SHALL change only on IDLE -> GRANT transition, never mid-grant.
REQ-024 A pending out_valid beat SHALL survive grant end and re-arbitration until accepted.
REQ-025 With one requester continuously asserting, throughput SHALL be BURST beats per BURST+1 cycles (one IDLE cycle per rotation).

Reset
REQ-026 reset=1 at a clock edge SHALL force state IDLE, owner=0, ptr=0, cnt=0, sel=00, out_data=0, out_valid=0 next cycle, overriding any beat in progress.
REQ-027 gnt SHALL be 0 while reset=1.
REQ-028 After reset deassertion, first grant SHALL be issuable one cycle after first req sample.

Verification
REQ-029 Reset mid-grant: owner=2 with cnt=2, assert reset one cycle -> sel=00, out_valid=0, out_data=0, gnt=0; next req=4'b1000 -> sel=11.
REQ-030 Round-robin: req=4'b1111 held, out_ready=1, BURST=4 -> grant order 0,1,2,3,0, each exactly 4 gnt pulses, one IDLE cycle between.
REQ-031 Pointer wrap: after owner=3 finishes, req=4'b1001 -> next owner=0 (ptr wrapped to 0).
REQ-032 Backpressure: owner=1, data1=32'hDEADBEEF beat issued, out_ready=0 for 3 cycles -> out_valid=1, out_data=32'hDEADBEEF stable, gnt=0, cnt unchanged; out_ready=1 -> next beat gnt[1]=1.
REQ-033 Early release: owner=2, req[2] drops after 1 beat -> IDLE next cycle, ptr=3; with req=4'b0101 next owner=0.
REQ-034 Latency: req=4'b0010 at cycle 0 from IDLE -> gnt=4'b0010 at cycle 1, out_valid=1 and out_data=data1 at cycle 2.
